// File: rtl/reqack_retry_ctrl.sv
// rtl/reqack_retry_ctrl.sv - multi-channel req/ack controller with timeout and bounded retry
// Optional statistics counters built only when REQACK_STATS_EN is defined.
module reqack_retry_ctrl #(
    parameter int NCH       = 4,
    parameter int TW        = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic                                                  clk,
    input  logic                                                  rstn,
    input  logic [NCH-1:0]                                        start,
    input  logic                                                  clear,
    input  logic [TW-1:0]                                         timeout_lim,
    input  logic                                                  ack,
    output logic                                                  req,
    output logic [$clog2(NCH)-1:0]                                req_ch,
    output logic                                                  busy,
    output logic                                                  ok,
    output logic                                                  error,
    output logic [$clog2(NCH)-1:0]                                done_ch,
    output logic [TW-1:0]                                         val,
    output logic [((MAX_RETRY > 0) ? $clog2(MAX_RETRY+1) : 1)-1:0] retries,
    output logic [15:0]                                           ok_cnt,
    output logic [15:0]                                           err_cnt
);

    localparam int CW = $clog2(NCH);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CW-1:0] LAST_CH   = CW'(NCH - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQUEST = 3'd1,
        S_WAITACK = 3'd2,
        S_RETRY   = 3'd3,
        S_DONE    = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [NCH-1:0]  pending_q, pending_d;
    logic [CW-1:0]   req_ch_q, req_ch_d;
    logic [CW-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]   val_q, val_d;
    logic [TW-1:0]   lim_q, lim_d;
    logic [RW-1:0]   retries_q, retries_d;

    logic [NCH-1:0]  done_mask;
    logic [NCH-1:0]  req_vec;
    logic            any_req;
    logic [CW-1:0]   win;
    logic            timed_out;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            req_ch_q  <= '0;
            ptr_q     <= '0;
            val_q     <= '0;
            lim_q     <= '0;
            retries_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            req_ch_q  <= req_ch_d;
            ptr_q     <= ptr_d;
            val_q     <= val_d;
            lim_q     <= lim_d;
            retries_q <= retries_d;
        end
    end

    // ptr_q is the first channel examined: one past the last winner, 0 after reset.
    always_comb begin
        done_mask = '0;
        if (state_q == S_DONE || state_q == S_ERR) begin
            done_mask[req_ch_q] = 1'b1;
        end
        req_vec = (pending_q & ~done_mask) | start;
        any_req = 1'b0;
        win     = ptr_q;
        for (int i = 0; i < NCH; i++) begin
            int j;
            j = int'(ptr_q) + i;
            if (j >= NCH) begin
                j = j - NCH;
            end
            if (!any_req && req_vec[j]) begin
                any_req = 1'b1;
                win     = j[CW-1:0];
            end
        end
    end

    assign timed_out = (lim_q != '0) && (val_q == lim_q - TW'(1));

    // DONE/ERR arbitrate like IDLE so the next grant directly follows the pulse.
    always_comb begin
        state_d   = state_q;
        pending_d = req_vec;
        req_ch_d  = req_ch_q;
        ptr_d     = ptr_q;
        val_d     = val_q;
        lim_d     = lim_q;
        retries_d = retries_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (state_q != S_IDLE) begin
                    retries_d = '0;
                end
                if (any_req) begin
                    state_d  = S_REQUEST;
                    req_ch_d = win;
                    ptr_d    = (win == LAST_CH) ? '0 : win + CW'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQUEST: begin
                val_d   = '0;
                lim_d   = timeout_lim;
                state_d = S_WAITACK;
            end
            S_WAITACK: begin
                if (val_q != '1) begin
                    val_d = val_q + TW'(1);
                end
                if (ack) begin
                    state_d = S_DONE;
                end else if (timed_out) begin
                    state_d = (retries_q < RETRY_MAX) ? S_RETRY : S_ERR;
                end
            end
            S_RETRY: begin
                retries_d = retries_q + RW'(1);
                state_d   = S_REQUEST;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
        if (clear) begin
            state_d   = S_IDLE;
            pending_d = '0;
            retries_d = '0;
        end
    end

    always_comb begin
        req     = (state_q == S_WAITACK);
        busy    = (state_q == S_REQUEST) || (state_q == S_WAITACK) || (state_q == S_RETRY);
        ok      = (state_q == S_DONE);
        error   = (state_q == S_ERR);
        done_ch = (ok || error) ? req_ch_q : '0;
        req_ch  = req_ch_q;
        val     = val_q;
        retries = retries_q;
    end

`ifdef REQACK_STATS_EN
    logic [15:0] ok_cnt_q, ok_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        ok_cnt_d  = ok_cnt_q;
        err_cnt_d = err_cnt_q;
        if (ok && ok_cnt_q != 16'hFFFF) begin
            ok_cnt_d = ok_cnt_q + 16'd1;
        end
        if (error && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ok_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            ok_cnt_q  <= ok_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ok_cnt  = ok_cnt_q;
    assign err_cnt = err_cnt_q;
`else
    assign ok_cnt  = '0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_reqack_retry_ctrl.sv
// tb/tb_reqack_retry_ctrl.sv - scoreboard bench for reqack_retry_ctrl
module tb_reqack_retry_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  start;
    logic        clear;
    logic [7:0]  timeout_lim;
    logic        ack;
    logic        req;
    logic [1:0]  req_ch;
    logic        busy;
    logic        ok;
    logic        error;
    logic [1:0]  done_ch;
    logic [7:0]  val;
    logic [1:0]  retries;
    logic [15:0] ok_cnt;
    logic [15:0] err_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic kind;
        int   ch;
        int   at;
    } exp_t;

    exp_t exp_q[$];

    reqack_retry_ctrl #(.NCH(4), .TW(8), .MAX_RETRY(2)) dut (
        .clk(clk), .rstn(rstn), .start(start), .clear(clear),
        .timeout_lim(timeout_lim), .ack(ack), .req(req), .req_ch(req_ch),
        .busy(busy), .ok(ok), .error(error), .done_ch(done_ch), .val(val),
        .retries(retries), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_done(input logic kind, input int ch, input int at);
        exp_t e;
        e.kind = kind;
        e.ch   = ch;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // Drives ack in the current WAITACK cycle; ok is due on the next cycle.
    task automatic ack_issue(input int ch);
        expect_done(1'b0, ch, cyc + 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rstn && (ok || error)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL done_evt @cyc %0d: got ok=%0b err=%0b ch=%0d, none expected",
                         cyc, ok, error, done_ch);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (error !== e.kind || ok !== !e.kind || int'(done_ch) != e.ch || cyc != e.at) begin
                    bad++;
                    $display("FAIL done_evt: got err=%0b ok=%0b ch=%0d cyc=%0d, expected err=%0b ch=%0d cyc=%0d",
                             error, ok, done_ch, cyc, e.kind, e.ch, e.at);
                end
            end
        end
    end

    logic req_pat3 [7]  = '{0, 1, 1, 1, 0, 0, 1};
    logic req_pat4 [11] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1};

    initial begin
        int stats_on;
        int t;
`ifdef REQACK_STATS_EN
        stats_on = 1;
`else
        stats_on = 0;
`endif
        rstn = 1'b0; start = '0; clear = 1'b0; timeout_lim = '0; ack = 1'b0;
        do_reset();

        chk("rst_req", 32'(req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ok_err", 32'({ok, error}), 0);
        chk("rst_req_ch", 32'(req_ch), 0);
        chk("rst_val", 32'(val), 0);
        chk("rst_retries", 32'(retries), 0);
        chk("rst_cnts", {ok_cnt, err_cnt}, 0);

        // single grant
        start = 4'b0001;
        step(); start = '0;
        chk("sg_busy", 32'(busy), 1);
        chk("sg_req_t1", 32'(req), 0);
        step(); chk("sg_req_t2", 32'(req), 1);
        chk("sg_req_ch", 32'(req_ch), 0);
        step(); chk("sg_req_t3", 32'(req), 1);
        step(); chk("sg_req_t4", 32'(req), 1);
        ack_issue(0);
        chk("sg_req_t5", 32'(req), 0);
        chk("sg_busy_t5", 32'(busy), 0);
        step();

        // round-robin from a fresh pointer
        do_reset();
        start = 4'b1011;
        step(); start = '0;
        chk("rr_g0", 32'(req_ch), 0);
        step(); chk("rr_req0", 32'(req), 1);
        ack_issue(0);
        chk("rr_done_req", 32'(req), 0);
        step(); chk("rr_g1", 32'(req_ch), 1);
        step(); chk("rr_req1", 32'(req), 1);
        ack_issue(1);
        step(); chk("rr_g3", 32'(req_ch), 3);
        step(); chk("rr_req3", 32'(req), 1);
        ack_issue(3);
        step(); chk("rr_idle", 32'(busy), 0);
        start = 4'b0001;
        step(); start = '0;
        chk("rr_g0b", 32'(req_ch), 0);
        step(); ack_issue(0);
        step();

        // retry then success
        timeout_lim = 8'd3;
        start = 4'b0100;
        step(); start = '0;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("rt_req_%0d", i + 1), 32'(req), 32'(req_pat3[i]));
            if (i == 3) chk("rt_val", 32'(val), 2);
            if (i != 6) step();
        end
        chk("rt_retries1", 32'(retries), 1);
        chk("rt_ch", 32'(req_ch), 2);
        ack_issue(2);
        step(); chk("rt_retries0", 32'(retries), 0);

        // retry exhaustion
        timeout_lim = 8'd2;
        start = 4'b0010;
        step(); start = '0;
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("ex_req_%0d", i + 1), 32'(req), 32'(req_pat4[i]));
            if (i != 10) step();
        end
        chk("ex_retries2", 32'(retries), 2);
        expect_done(1'b1, 1, cyc + 1);
        step(); chk("ex_req_err", 32'(req), 0);
        step();
        chk("ex_retries0", 32'(retries), 0);
        chk("ex_err_cnt", 32'(err_cnt), 32'(stats_on));
        chk("ex_ok_cnt", 32'(ok_cnt), 32'(stats_on * 5));

        // ack on the timeout cycle; a mid-wait limit change must not apply
        timeout_lim = 8'd4;
        start = 4'b1000;
        step(); start = '0;
        step(); chk("at_req_2", 32'(req), 1);
        timeout_lim = 8'd2;
        step(); chk("at_req_3", 32'(req), 1);
        step(); chk("at_req_4", 32'(req), 1);
        step(); chk("at_req_5", 32'(req), 1);
        ack_issue(3);
        chk("at_req_low", 32'(req), 0);
        chk("at_retries", 32'(retries), 0);
        step(); chk("at_no_retry", 32'(busy), 0);

        // clear mid-wait together with a start
        timeout_lim = 8'd0;
        start = 4'b0001;
        step(); start = '0;
        step(); chk("cl_req", 32'(req), 1);
        step(); clear = 1'b1; start = 4'b0100;
        step(); clear = 1'b0; start = '0;
        chk("cl_busy1", 32'(busy), 0);
        chk("cl_req_low", 32'(req), 0);
        step(); chk("cl_busy2", 32'(busy), 0);
        step(); chk("cl_busy3", 32'(busy), 0);

        // no timeout when limit is 0; val saturates
        start = 4'b0001;
        step(); start = '0;
        t = cyc;
        repeat (300) step();
        chk("sat_req", 32'(req), 1);
        chk("sat_busy", 32'(busy), 1);
        chk("sat_val", 32'(val), 255);
        clear = 1'b1;
        step(); clear = 1'b0;
        chk("sat_clr_busy", 32'(busy), 0);
        step(); chk("sat_val_hold", 32'(val), 255);

        repeat (3) step();
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
